// File: rtl/mmio_input_port.sv
// mmio_input_port: memory-mapped switch/key input peripheral for the memory stage.
// Switches and active-low keys go through a two-flop synchroniser. Each key then
// has its own debounce counter and STABLE/COUNTING state machine. Key presses are
// latched as read-to-clear edge flags. Reads have one cycle of latency.
// All state updates on the falling edge of I_CLOCK. I_LOCK is an async active-low reset.
// Optional build macro MMIO_SW_DEBOUNCE_EN: when defined, the switches are debounced
// exactly like the keys. By default they come straight from the synchroniser.

module mmio_input_port #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [9:0]  ADDR_SW         = 10'h3F8,
    parameter logic [9:0]  ADDR_KEY        = 10'h3F9,
    parameter logic [9:0]  ADDR_KEYEDGE    = 10'h3FA
) (
    input  logic        I_CLOCK,
    input  logic        I_LOCK,
    input  logic [9:0]  I_SW,
    input  logic [3:0]  I_KEY,
    input  logic        I_ReadEn,
    input  logic [9:0]  I_Addr,
    output logic [15:0] O_ReadData,
    output logic        O_ReadValid
);

    localparam int unsigned SW_W   = 10;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef MMIO_SW_DEBOUNCE_EN
    localparam int unsigned N_DEB = KEY_W + SW_W;
`else
    localparam int unsigned N_DEB = KEY_W;
`endif

    typedef enum logic {
        DEB_STABLE   = 1'b0,
        DEB_COUNTING = 1'b1
    } deb_state_t;

    logic [SW_W-1:0]   sw_meta;
    logic [SW_W-1:0]   sw_sync;
    logic [KEY_W-1:0]  key_meta;
    logic [KEY_W-1:0]  key_sync;

    logic [N_DEB-1:0]  deb_sample_c;
    logic [N_DEB-1:0]  deb_level;
    logic [KEY_W-1:0]  key_rise_c;
    logic [KEY_W-1:0]  key_level;
    logic [SW_W-1:0]   sw_level;

    logic [KEY_W-1:0]  edge_flags;
    logic [KEY_W-1:0]  edge_clr_c;
    logic [DATA_W-1:0] read_mux_c;

    // Two-flop synchroniser; keys are inverted so that pressed reads as 1
    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '0;
            key_sync <= '0;
        end else begin
            sw_meta  <= I_SW;
            sw_sync  <= sw_meta;
            key_meta <= ~I_KEY;
            key_sync <= key_meta;
        end
    end

`ifdef MMIO_SW_DEBOUNCE_EN
    assign deb_sample_c = {sw_sync, key_sync};
    assign sw_level     = deb_level[KEY_W +: SW_W];
`else
    assign deb_sample_c = key_sync;
    assign sw_level     = sw_sync;
`endif
    assign key_level = deb_level[KEY_W-1:0];

    // One debounce counter and state machine per debounced input bit
    for (genvar i = 0; i < N_DEB; i++) begin : g_deb
        deb_state_t       state;
        logic [CNT_W-1:0] cnt;
        logic             level;
        logic             differ_c;
        logic             accept_c;

        assign differ_c     = deb_sample_c[i] ^ level;
        assign accept_c     = differ_c && (cnt == CNT_LAST);
        assign deb_level[i] = level;

        // A key press is the accepted 0->1 change of a key's debounced level
        if (i < KEY_W) begin : g_rise
            assign key_rise_c[i] = accept_c & deb_sample_c[i];
        end

        // Accept a level change only after DEBOUNCE_CYCLES differing samples in a row
        always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
            if (!I_LOCK) begin
                state <= DEB_STABLE;
                cnt   <= '0;
                level <= 1'b0;
            end else begin
                case (state)
                    DEB_STABLE: begin
                        if (differ_c) begin
                            if (accept_c) begin
                                level <= deb_sample_c[i];
                            end else begin
                                state <= DEB_COUNTING;
                                cnt   <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    DEB_COUNTING: begin
                        if (!differ_c) begin
                            cnt   <= '0;
                            state <= DEB_STABLE;
                        end else if (accept_c) begin
                            level <= deb_sample_c[i];
                            cnt   <= '0;
                            state <= DEB_STABLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= DEB_STABLE;
                    end
                endcase
            end
        end
    end

    // Address decode for the read window; unmapped addresses read as zero
    always_comb begin
        read_mux_c = '0;
        edge_clr_c = '0;
        if (I_Addr == ADDR_SW) begin
            read_mux_c = {6'b0, sw_level};
        end else if (I_Addr == ADDR_KEY) begin
            read_mux_c = {12'b0, key_level};
        end else if (I_Addr == ADDR_KEYEDGE) begin
            read_mux_c = {12'b0, edge_flags};
        end
        if (I_ReadEn && (I_Addr == ADDR_KEYEDGE)) begin
            edge_clr_c = edge_flags;
        end
    end

    // Edge flags: clear what a read returned, and a same-edge press wins over the clear
    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            edge_flags <= '0;
        end else begin
            edge_flags <= (edge_flags & ~edge_clr_c) | key_rise_c;
        end
    end

    // Registered read response; data holds while no read is issued
    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            O_ReadData  <= '0;
            O_ReadValid <= 1'b0;
        end else if (I_ReadEn) begin
            O_ReadData  <= read_mux_c;
            O_ReadValid <= 1'b1;
        end else begin
            O_ReadValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_input_port.sv
// Scoreboard bench for mmio_input_port with DEBOUNCE_CYCLES=4. Inputs change on
// the rising edge and outputs are sampled on the rising edge. The DUT acts on the
// falling edge. Expected read data are pushed into a queue when a read is issued,
// and a separate monitor pops and compares them when O_ReadValid is seen.

module tb_mmio_input_port;

    localparam logic [9:0] A_SW   = 10'h3F8;
    localparam logic [9:0] A_KEY  = 10'h3F9;
    localparam logic [9:0] A_EDGE = 10'h3FA;
`ifdef MMIO_SW_DEBOUNCE_EN
    localparam int SW_LAT = 6;
`else
    localparam int SW_LAT = 2;
`endif

    logic        clk;
    logic        I_LOCK;
    logic [9:0]  I_SW;
    logic [3:0]  I_KEY;
    logic        I_ReadEn;
    logic [9:0]  I_Addr;
    logic [15:0] O_ReadData;
    logic        O_ReadValid;

    int passed = 0;
    int total  = 0;
    logic [15:0] exp_q[$];
    string       name_q[$];

    mmio_input_port #(
        .DEBOUNCE_CYCLES(4),
        .ADDR_SW        (A_SW),
        .ADDR_KEY       (A_KEY),
        .ADDR_KEYEDGE   (A_EDGE)
    ) dut (
        .I_CLOCK    (clk),
        .I_LOCK     (I_LOCK),
        .I_SW       (I_SW),
        .I_KEY      (I_KEY),
        .I_ReadEn   (I_ReadEn),
        .I_Addr     (I_Addr),
        .O_ReadData (O_ReadData),
        .O_ReadValid(O_ReadValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 16'h%04h expected 16'h%04h at %0t", nm, act, exp, $time);
    endtask

    // Issue one read at the current rising edge and queue its expected data
    task automatic rd(input logic [9:0] a, input logic [15:0] e, input string nm);
        I_ReadEn = 1'b1;
        I_Addr   = a;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        I_ReadEn = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    // Monitor: every valid response is compared against the oldest queued expectation
    always @(posedge clk) begin
        if (I_LOCK && O_ReadValid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_valid: got data 16'h%04h with no read pending at %0t", O_ReadData, $time);
            end else begin
                check(name_q.pop_front(), O_ReadData, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        I_LOCK   = 1'b0;
        I_KEY    = 4'hF;
        I_SW     = 10'h3FF;
        I_ReadEn = 1'b1;
        I_Addr   = A_KEY;

        // Reset holds outputs at zero even with a read requested
        repeat (3) @(posedge clk);
        check("reset_valid", {15'b0, O_ReadValid}, 16'h0000);
        check("reset_data", O_ReadData, 16'h0000);
        I_LOCK   = 1'b1;
        I_SW     = 10'h000;
        idle(3);
        rd(A_KEY, 16'h0000, "key_after_reset");
        rd(A_EDGE, 16'h0000, "edge_after_reset");

        // Clean press of key1: debounced level visible after 6 falling edges
        I_KEY = 4'b1101;
        for (int i = 0; i < 8; i++)
            rd(A_KEY, (i >= 6) ? 16'h0002 : 16'h0000, $sformatf("press_key_%0d", i));
        rd(A_EDGE, 16'h0002, "press_edge");
        rd(A_EDGE, 16'h0000, "press_edge_reread");
        I_KEY = 4'hF;
        idle(10);
        rd(A_EDGE, 16'h0000, "release_edge");
        rd(A_KEY, 16'h0000, "release_key");

        // Bounce on key0 with period 4 never reaches 4 stable samples
        for (int c = 0; c < 5; c++) begin
            I_KEY = 4'hE;
            rd(A_KEY, 16'h0000, "bounce_key_lo");
            rd(A_KEY, 16'h0000, "bounce_key_lo");
            I_KEY = 4'hF;
            rd(A_KEY, 16'h0000, "bounce_key_hi");
            rd(A_KEY, 16'h0000, "bounce_key_hi");
        end
        idle(8);
        rd(A_EDGE, 16'h0000, "bounce_edge");
        rd(A_KEY, 16'h0000, "bounce_key_final");

        // Switch latency
        I_SW = 10'h2A5;
        for (int i = 0; i < 8; i++)
            rd(A_SW, (i >= SW_LAT) ? 16'h02A5 : 16'h0000, $sformatf("sw_%0d", i));

        // Clear race: key3 press lands on the same edge as an edge-flag read
        I_KEY = 4'b1011;
        idle(10);
        rd(A_KEY, 16'h0004, "race_key2");
        I_KEY = 4'b0011;
        idle(5);
        rd(A_EDGE, 16'h0004, "race_first");
        rd(A_EDGE, 16'h0008, "race_second");
        rd(A_EDGE, 16'h0000, "race_third");
        rd(A_KEY, 16'h000C, "race_keys");
        I_KEY = 4'hF;
        idle(10);
        rd(A_EDGE, 16'h0000, "race_release_edge");

        // Unmapped address, then idle: valid drops and data holds
        rd(10'h3FB, 16'h0000, "unmapped");
        rd(A_SW, 16'h02A5, "sw_before_idle");
        I_ReadEn = 1'b0;
        @(posedge clk);
        @(posedge clk);
        check("idle_valid", {15'b0, O_ReadValid}, 16'h0000);
        check("idle_data_hold", O_ReadData, 16'h02A5);

        // Reset mid-debounce: held key is re-debounced and flagged again
        I_KEY = 4'hE;
        idle(4);
        I_LOCK = 1'b0;
        idle(2);
        I_LOCK = 1'b1;
        idle(8);
        rd(A_EDGE, 16'h0001, "rst_mid_edge");
        rd(A_KEY, 16'h0001, "rst_mid_key");
        I_KEY = 4'hF;
        idle(10);
        rd(A_EDGE, 16'h0000, "rst_mid_release_edge");

        idle(3);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
